// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// Each clock shifts the working register right one bit and subtracts 3 from
// every BCD nibble that lands at 8 or above. Start/busy/done handshake, one
// conversion in flight. Optional build macro BCD2BIN_CHECK_EN rejects operands
// containing a nibble above 9 at the accepting edge (done+err, bin=0).
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BCD_W = 4 * DIGITS;
    // The binary half is as wide as the number of shifts, so every bit that
    // leaves the BCD half is kept; the result is resized to BIN_W on output.
    localparam int SR_W  = 2 * BCD_W;
    localparam int CNT_W = $clog2(BCD_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCD_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SR_W-1:0]   sreg;
    logic [SR_W-1:0]   sreg_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              invalid;
    logic              accept;
    logic              last;

    assign accept = (state == IDLE) && start && !invalid;
    assign last   = (state == SHIFT) && (cnt == LAST_CNT);

`ifdef BCD2BIN_CHECK_EN
    logic reject;
    assign reject = (state == IDLE) && start && invalid;

    // Flag an operand that contains any nibble above 9.
    always_comb begin
        invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) invalid = 1'b1;
        end
    end
`else
    assign invalid = 1'b0;
`endif

    // One reverse double-dabble iteration: shift right, then correct all
    // BCD nibbles in parallel.
    // NOTE: combinational blocks use blocking '=' with a default first, so the
    // corrected nibbles build on the shifted value and no latch is inferred.
    always_comb begin
        sreg_nxt = sreg >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg_nxt[BCD_W + 4*i +: 4] >= 4'd8)
                sreg_nxt[BCD_W + 4*i +: 4] = sreg_nxt[BCD_W + 4*i +: 4] - 4'd3;
        end
    end

    // State register.
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples
    // pre-edge values; reset is asynchronous and takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: leave IDLE on an accepted start, return on the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: busy for exactly the SHIFT phase.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Datapath: load operand, iterate, publish result with a one-cycle done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            bin  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sreg <= {bcd, {BCD_W{1'b0}}};
                cnt  <= '0;
            end else if (state == SHIFT) begin
                sreg <= sreg_nxt;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    bin  <= BIN_W'(sreg_nxt[BCD_W-1:0]);
                    done <= 1'b1;
                end
            end
`ifdef BCD2BIN_CHECK_EN
            if (reject) begin
                bin  <= '0;
                done <= 1'b1;
            end
`endif
        end
    end

`ifdef BCD2BIN_CHECK_EN
    // Error flag: set by a rejected operand, cleared by the next valid result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err <= 1'b0;
        else if (reject) err <= 1'b1;
        else if (last)   err <= 1'b0;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed and exhaustive bench for bcd2bin_seq with a
// scoreboard queue filled at start and drained by a done monitor.
// Build with BCD2BIN_CHECK_EN defined to also exercise invalid-digit rejection.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [9:0] bin;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Done monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("bin", 32'(bin), 32'(e.bin));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    function automatic logic [9:0] bcd_value(input logic [11:0] v);
        return 10'(v[11:8] * 100 + v[7:4] * 10 + v[3:0]);
    endfunction

    // Wait (bounded) for the scoreboard to drain.
    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Wait (bounded) for a done pulse and report the cycle it was seen.
    task automatic wait_done_cyc(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                c = cyc;
                break;
            end
        end
        check("done_seen", 32'(c >= 0), 32'd1);
    endtask

    // Single start pulse with a valid operand, then wait for its result.
    task automatic convert(input logic [11:0] v);
        exp_t e;
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        e.bin = bcd_value(v);
        e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 12'(($urandom));
        wait_drain();
    endtask

    initial begin
        exp_t e;
        int   c1;
        int   c2;

        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_bin",  32'(bin),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 999 with latency and busy window; bcd scrambled after acceptance.
        bcd   = 12'h999;
        start = 1'b1;
        e.bin = 10'd999;
        e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 12'hABC;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("busy_%0d", i), 32'(busy), 32'd1);
            check($sformatf("nodone_%0d", i), 32'(done), 32'd0);
        end
        @(negedge clk);
        check("lat_done", 32'(done), 32'd1);
        check("lat_busy", 32'(busy), 32'd0);
        #1;
        check("lat_drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("bin_hold", 32'(bin), 32'd999);

        // 2: assorted values.
        convert(12'h000);
        convert(12'h255);
        convert(12'h100);

        // 3: start held high; two results 13 clocks apart, no extra done.
        @(negedge clk);
        bcd   = 12'h042;
        start = 1'b1;
        e.bin = 10'd42;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bcd   = 12'h317;
        e.bin = 10'd317;
        sb.push_back(e);
        wait_done_cyc(c1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done_cyc(c2);
        check("b2b_period", 32'(c2 - c1), 32'd13);
        repeat (20) @(negedge clk);
        check("b2b_drain", 32'(sb.size()), 32'd0);

        // 4: reset mid-conversion aborts; next conversion is clean.
        @(negedge clk);
        bcd   = 12'h999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_bin",  32'(bin),  32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err",  32'(err),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        convert(12'h123);

`ifdef BCD2BIN_CHECK_EN
        // 5: invalid digit rejected at the accepting edge.
        @(negedge clk);
        bcd   = 12'h1A3;
        start = 1'b1;
        e.bin = 10'd0;
        e.err = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("inv_done", 32'(done), 32'd1);
        check("inv_busy", 32'(busy), 32'd0);
        check("inv_bin",  32'(bin),  32'd0);
        check("inv_err",  32'(err),  32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("inv_nobusy", 32'(busy), 32'd0);
        end
        convert(12'h050);
        check("err_clear", 32'(err), 32'd0);
`endif

        // 6: exhaustive valid operands.
        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    convert({4'(d2), 4'(d1), 4'(d0)});
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
